button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter NUM_BTN, default 2, number of independent button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 120000 (10 ms at 12 MHz), consecutive stable cycles required to accept a change; legal range 1 to 2^20-1.
REQ-003 The block SHALL have parameter ACTIVE_LOW_IN, default 0; when 1, each pin is inverted before synchronisation.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-005 The block SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port btn_raw, input, NUM_BTN bits, asynchronous board button pins (BUT1 = bit 0, BUT2 = bit 1).
REQ-007 The block SHALL have port btn_level, output, NUM_BTN bits, debounced level; bits 0/1 drive the core's io_cond0/io_cond1.
REQ-008 The block SHALL have port btn_press, output, NUM_BTN bits, one-cycle pulse on an accepted 0->1 change.
REQ-009 The block SHALL have port btn_release, output, NUM_BTN bits, one-cycle pulse on an accepted 1->0 change.

Function
REQ-010 Each channel SHALL pass its (optionally inverted) pin through a two-flop synchroniser; only the second-stage value (sync) is used downstream.
REQ-011 Each channel SHALL run a four-state FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-012 STABLE_LO with sync=1 SHALL go to WAIT_HI with counter cleared to 0; STABLE_HI with sync=0 SHALL go to WAIT_LO with counter cleared to 0.
REQ-013 In WAIT_HI/WAIT_LO, each cycle with sync still at the new value SHALL increment the counter; sync reverting SHALL return to the originating STABLE state and clear the counter, with no pulse.
REQ-014 When the counter equals DEBOUNCE_CYCLES-1 and sync still holds the new value, the FSM SHALL move to the new STABLE state on the next edge, update btn_level on that edge, and assert btn_press (or btn_release) for exactly that one cycle.
REQ-015 Latency from the first clk edge sampling a clean pin change to the btn_level change SHALL be exactly DEBOUNCE_CYCLES+2 edges.
REQ-016 The counter SHALL be sized ceil(log2(DEBOUNCE_CYCLES+1)) bits, SHALL never wrap, and SHALL be held at 0 in both STABLE states.
REQ-017 btn_press and btn_release for the same channel SHALL never be asserted in the same cycle; a pulse SHALL never repeat while the level is held.
REQ-018 Channels SHALL be fully independent; simultaneous accepted changes on several channels SHALL each produce their own pulse in the same cycle.
REQ-019 DEBOUNCE_CYCLES=1 SHALL be legal: a change held for one sync cycle is accepted.

Reset
REQ-020 Asserting resetn low SHALL immediately clear synchronisers, counters, btn_level, btn_press and btn_release to 0 and force every FSM to STABLE_LO, including mid-WAIT.
REQ-021 After resetn deasserts, a button already pressed SHALL be accepted as a normal press after DEBOUNCE_CYCLES+2 edges, with one btn_press pulse.

Structure
REQ-022 The FSM state enum and the counter-width function SHALL live in shared package button_pkg.
REQ-023 One channel (synchroniser, FSM, counter, pulse logic) SHALL be sub-module button_debounce_channel, instantiated NUM_BTN times by a generate loop; the top level SHALL contain no other logic.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW_IN=0)
REQ-024 The bench SHALL check that btn_raw[0] 0->1 held 20 cycles gives btn_level[0]=1 exactly 6 edges after the first sampling edge, with btn_press[0]=1 in that single cycle only.
REQ-025 The bench SHALL check that btn_raw[0] bouncing 1,0,1,0 at 2-cycle intervals then held 1 gives no pulse during the bounce and exactly one btn_press[0] 6 edges after the final rise.
REQ-026 The bench SHALL check that both bits of btn_raw rising on the same edge give btn_press=2'b11 in one cycle and btn_level=2'b11 afterwards.
REQ-027 The bench SHALL check that resetn pulsed low during WAIT_HI gives all outputs 0 immediately, and that with btn_raw[1] still 1 one btn_press[1] occurs 6 edges after release.
REQ-028 The bench SHALL check that a 1->0 change after a stable high gives btn_release for exactly one cycle, with btn_press=0 throughout.
REQ-029 The bench SHALL check that, with ACTIVE_LOW_IN=1 and btn_raw=2'b11 at reset release, btn_level stays 0 and no pulse occurs for 50 cycles.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the button conditioning block.
// Holds the per-channel FSM state encoding and the debounce counter sizing rule.
package button_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } db_state_t;

   // Bits needed to hold 0..cycles without wrapping.
   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: optional inversion, two-flop synchroniser, debounce FSM
// with a stability counter, and registered level / press / release outputs.
module button_debounce_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter bit ACTIVE_LOW_IN   = 1'b0
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       pin,
   output logic       level,
   output logic       press,
   output logic       release_pulse,
   output logic [1:0] state_dbg
);

   localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          pin_in;
   logic          sync1, sync2;
   db_state_t     state, state_n;
   logic [CW-1:0] count, count_n;
   logic          level_n, press_n, release_n;

   assign pin_in    = ACTIVE_LOW_IN ? ~pin : pin;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1         <= 1'b0;
         sync2         <= 1'b0;
         state         <= STABLE_LO;
         count         <= '0;
         level         <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         sync1         <= pin_in;
         sync2         <= sync1;
         state         <= state_n;
         count         <= count_n;
         level         <= level_n;
         press         <= press_n;
         release_pulse <= release_n;
      end
   end

   // Counter defaults to 0 so both STABLE states and every abort clear it.
   always_comb begin
      state_n   = state;
      count_n   = '0;
      level_n   = level;
      press_n   = 1'b0;
      release_n = 1'b0;
      case (state)
         STABLE_LO: if (sync2) state_n = WAIT_HI;
         WAIT_HI: begin
            if (!sync2) begin
               state_n = STABLE_LO;
            end else if (count == LAST) begin
               state_n = STABLE_HI;
               level_n = 1'b1;
               press_n = 1'b1;
            end else begin
               count_n = count + CW'(1);
            end
         end
         STABLE_HI: if (!sync2) state_n = WAIT_LO;
         WAIT_LO: begin
            if (sync2) begin
               state_n = STABLE_HI;
            end else if (count == LAST) begin
               state_n   = STABLE_LO;
               level_n   = 1'b0;
               release_n = 1'b1;
            end else begin
               count_n = count + CW'(1);
            end
         end
         default: state_n = STABLE_LO;
      endcase
   end

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BTN asynchronous board buttons into clean levels and edge pulses.
// Each bit is handled by an independent button_debounce_channel instance.
module button_conditioner
   import button_pkg::*;
#(
   parameter int NUM_BTN         = 2,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter bit ACTIVE_LOW_IN   = 1'b0
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NUM_BTN-1:0]   btn_raw,
   output logic [NUM_BTN-1:0]   btn_level,
   output logic [NUM_BTN-1:0]   btn_press,
   output logic [NUM_BTN-1:0]   btn_release,
   output logic [2*NUM_BTN-1:0] dbg_state
);

   // btn_press / btn_release are single-cycle strobes with no handshake:
   // a consumer must sample them on the cycle they are high.
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      button_debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .ACTIVE_LOW_IN  (ACTIVE_LOW_IN)
      ) u_chan (
         .clk          (clk),
         .resetn       (resetn),
         .pin          (btn_raw[i]),
         .level        (btn_level[i]),
         .press        (btn_press[i]),
         .release_pulse(btn_release[i]),
         .state_dbg    (dbg_state[2*i +: 2])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing,
// with a window-based reference model feeding a per-cycle scoreboard.
module tb_button_conditioner;

   localparam int NB  = 2;
   localparam int DEB = 4;
   localparam int LAT = DEB + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic [NB-1:0]   btn_raw, raw_al;
   logic [NB-1:0]   btn_level, btn_press, btn_release;
   logic [NB-1:0]   al_level, al_press, al_release;
   logic [2*NB-1:0] dbg_state, al_dbg_state;

   button_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW_IN(1'b0)) dut (
      .clk(clk), .resetn(resetn), .btn_raw(btn_raw), .btn_level(btn_level),
      .btn_press(btn_press), .btn_release(btn_release), .dbg_state(dbg_state)
   );

   button_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW_IN(1'b1)) dut_al (
      .clk(clk), .resetn(resetn), .btn_raw(raw_al), .btn_level(al_level),
      .btn_press(al_press), .btn_release(al_release), .dbg_state(al_dbg_state)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // A change is accepted once the synchronised input (pin delayed two edges)
   // has disagreed with the current level on DEB+1 consecutive edges.
   logic [3*NB-1:0] exp_q[$];
   logic [NB-1:0]   raw_hist[$];
   logic [NB-1:0]   sync_hist[$];
   logic [NB-1:0]   m_level = '0;

   initial begin
      logic [NB-1:0] s, p, r, v;
      bit all_diff;
      forever begin
         @(posedge clk);
         p = '0;
         r = '0;
         if (!resetn) begin
            raw_hist.delete();
            sync_hist.delete();
            m_level = '0;
         end else begin
            raw_hist.push_back(btn_raw);
            s = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size()-3] : '0;
            sync_hist.push_back(s);
            for (int ch = 0; ch < NB; ch++) begin
               if (sync_hist.size() >= DEB + 1) begin
                  all_diff = 1'b1;
                  for (int k = 0; k <= DEB; k++) begin
                     v = sync_hist[sync_hist.size()-1-k];
                     if (v[ch] == m_level[ch]) all_diff = 1'b0;
                  end
                  if (all_diff) begin
                     m_level[ch] = ~m_level[ch];
                     if (m_level[ch]) p[ch] = 1'b1;
                     else             r[ch] = 1'b1;
                  end
               end
            end
            if (raw_hist.size() > 32)  void'(raw_hist.pop_front());
            if (sync_hist.size() > 32) void'(sync_hist.pop_front());
         end
         exp_q.push_back({m_level, r, p});
      end
   end

   // ---------------- scoreboard monitor ----------------
   int press_cnt[NB];
   int rel_cnt[NB];

   initial begin
      logic [3*NB-1:0] e;
      for (int ch = 0; ch < NB; ch++) begin
         press_cnt[ch] = 0;
         rel_cnt[ch]   = 0;
      end
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("scoreboard", {26'd0, btn_level, btn_release, btn_press}, {26'd0, e});
         end
         for (int ch = 0; ch < NB; ch++) begin
            press_cnt[ch] += int'(btn_press[ch]);
            rel_cnt[ch]   += int'(btn_release[ch]);
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic wait_level(input int ch, input logic val, output int edges);
      edges = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         edges++;
         if (btn_level[ch] == val) break;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int e, p0, r0;
      int hold[NB];
      resetn  = 1'b0;
      btn_raw = '0;
      raw_al  = '1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", {26'd0, btn_level, btn_release, btn_press}, 32'd0);
      chk("reset_state", {28'd0, dbg_state}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Active-low instance with both pins held high sees no press.
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("active_low_idle", {26'd0, al_level, al_release, al_press}, 32'd0);
      end

      // Clean press on channel 0.
      p0 = press_cnt[0];
      btn_raw[0] = 1'b1;
      wait_level(0, 1'b1, e);
      chk("press_latency", e - 1, LAT);
      chk("press_pulse", {30'd0, btn_press}, 32'd1);
      repeat (14) @(negedge clk);
      #1;
      chk("press_once", press_cnt[0] - p0, 1);

      // Clean release on channel 0.
      @(negedge clk);
      p0 = press_cnt[0];
      r0 = rel_cnt[0];
      btn_raw[0] = 1'b0;
      wait_level(0, 1'b0, e);
      chk("release_latency", e - 1, LAT);
      chk("release_pulse", {30'd0, btn_release}, 32'd1);
      repeat (14) @(negedge clk);
      #1;
      chk("release_once", rel_cnt[0] - r0, 1);
      chk("release_no_press", press_cnt[0] - p0, 0);

      // Bounce 1,0,1,0 at 2-cycle intervals, then hold high.
      @(negedge clk);
      p0 = press_cnt[0];
      for (int i = 0; i < 4; i++) begin
         btn_raw[0] = (i % 2 == 0);
         repeat (2) @(negedge clk);
      end
      #1;
      chk("bounce_no_pulse", press_cnt[0] - p0, 0);
      btn_raw[0] = 1'b1;
      wait_level(0, 1'b1, e);
      chk("bounce_latency", e - 1, LAT);
      repeat (12) @(negedge clk);
      #1;
      chk("bounce_one_press", press_cnt[0] - p0, 1);

      // Simultaneous press on both channels.
      @(negedge clk);
      btn_raw = 2'b00;
      wait_level(0, 1'b0, e);
      @(negedge clk);
      btn_raw = 2'b11;
      wait_level(0, 1'b1, e);
      chk("dual_latency", e - 1, LAT);
      chk("dual_press", {30'd0, btn_press}, 32'd3);
      repeat (4) @(negedge clk);
      #1;
      chk("dual_level", {30'd0, btn_level}, 32'd3);

      // Reset in the middle of WAIT_HI on channel 1.
      @(negedge clk);
      btn_raw[1] = 1'b0;
      wait_level(1, 1'b0, e);
      @(negedge clk);
      btn_raw[1] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      chk("reset_async_outputs", {26'd0, btn_level, btn_release, btn_press}, 32'd0);
      chk("reset_async_state", {28'd0, dbg_state}, 32'd0);
      @(negedge clk);
      p0 = press_cnt[1];
      resetn = 1'b1;
      wait_level(1, 1'b1, e);
      chk("post_reset_latency", e - 1, LAT);
      chk("post_reset_press", {31'd0, btn_press[1]}, 32'd1);
      repeat (10) @(negedge clk);
      #1;
      chk("post_reset_once", press_cnt[1] - p0, 1);

      // Random bouncing with occasional resets.
      for (int ch = 0; ch < NB; ch++) hold[ch] = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #2;
         for (int ch = 0; ch < NB; ch++) begin
            if (hold[ch] == 0) begin
               btn_raw[ch] = 1'($urandom_range(0, 1));
               hold[ch]    = $urandom_range(1, 10);
            end
            hold[ch]--;
         end
         resetn = ($urandom_range(0, 149) != 0);
      end
      @(negedge clk);
      #2;
      resetn = 1'b1;

      repeat (4) @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
